// File: rtl/hififo_request_arbiter.sv
// hififo_request_arbiter
//   Round-robin arbiter sharing the single PCIe TX request path between up to
//   eight DMA channels. Read requests get a {src, seq} tag, in-flight reads are
//   limited per channel, and RX completions retire read tags.
//
// Ports
//   clock, reset           core clock, asynchronous active-high reset
//   req_valid/write/addr   per-requester request (addr is 64 bits per requester)
//   req_ready              one-hot (or zero) grant, combinational in IDLE
//   out_valid/ready        handshake towards pcie_tx
//   out_write/addr/tag/src registered request presented to pcie_tx
//   cpl_valid/tag/last     completion beats from the RX path
//   outstanding            4-bit in-flight read count per requester
//   cpl_error              sticky: completion for an idle or non-existent requester

module hififo_request_arbiter #(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [64*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_write,
    output logic [63:0]          out_addr,
    output logic [7:0]           out_tag,
    output logic [2:0]           out_src,
    input  logic                 cpl_valid,
    input  logic [7:0]           cpl_tag,
    input  logic                 cpl_last,
    output logic [4*NREQ-1:0]    outstanding,
    output logic                 cpl_error
);

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned SEQ_W  = 5;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [SRC_W-1:0]  src;
    } tx_req_t;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEQ_W-1:0]    seq_q [NREQ];
    logic [SEQ_W-1:0]    seq_d [NREQ];
    logic [CNT_W-1:0]    cnt_q [NREQ];
    logic [CNT_W-1:0]    cnt_d [NREQ];
    logic                cpl_error_q, cpl_error_d;
    tx_req_t             out_q, out_d;

    logic [NREQ-1:0]     eligible;
    logic                win_found;
    logic [SRC_W-1:0]    win_idx;
    int unsigned         cand;
    logic                win_write;
    logic [ADDR_W-1:0]   win_addr;
    logic [SEQ_W-1:0]    win_seq;
    logic                accept;
    logic                accept_read;
    logic                cpl_ret;
    logic [SRC_W-1:0]    cpl_src;
    logic [NREQ-1:0]     inc_v;
    logic [NREQ-1:0]     dec_v;
    logic                cpl_seq_unused;

    // Only the source field of a completion tag matters here.
    assign cpl_src        = cpl_tag[7:5];
    assign cpl_seq_unused = ^cpl_tag[4:0];
    assign cpl_ret        = cpl_valid & cpl_last;

    // A read is eligible only while its channel has a free in-flight slot.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i]
                        & (req_write[i] | (cnt_q[i] < CNT_W'(MAX_OUTSTANDING)));
        end
    end

    // Search upward from rr_ptr with wrap; first eligible candidate wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!win_found && (cand == i) && eligible[i]) begin
                    win_found = 1'b1;
                    win_idx   = SRC_W'(i);
                end
            end
        end
    end

    // Mux the winning requester's payload.
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_seq   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == SRC_W'(i)) begin
                win_write = req_write[i];
                win_addr  = req_addr[ADDR_W*i +: ADDR_W];
                win_seq   = seq_q[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found) state_d = ST_SEND;
            ST_SEND: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; grants are suppressed while reset is held.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        out_valid = (state_q == ST_SEND);
        if ((state_q == ST_IDLE) && !reset && win_found) begin
            accept = 1'b1;
            for (int unsigned i = 0; i < NREQ; i++) begin
                req_ready[i] = (win_idx == SRC_W'(i));
            end
        end
    end

    assign accept_read = accept & ~win_write;

    // Per-requester increment/decrement strobes for the in-flight counters.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            inc_v[i] = accept_read & (win_idx == SRC_W'(i));
            dec_v[i] = cpl_ret & (cpl_src == SRC_W'(i));
        end
    end

    // Counter, sequence, error and round-robin pointer next-state.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            seq_d[i] = seq_q[i];
        end
        cpl_error_d = cpl_error_q;
        rr_ptr_d    = rr_ptr_q;

        if (cpl_ret && (32'(cpl_src) >= NREQ)) begin
            cpl_error_d = 1'b1;
        end

        for (int unsigned i = 0; i < NREQ; i++) begin
            if (dec_v[i] && (cnt_q[i] == '0)) begin
                cpl_error_d = 1'b1;
            end
            // Simultaneous increment and decrement cancel out.
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (inc_v[i]) begin
                seq_d[i] = seq_q[i] + SEQ_W'(1);
            end
        end

        if (accept) begin
            rr_ptr_d = ((32'(win_idx) + 1) >= NREQ) ? '0 : win_idx + SRC_W'(1);
        end
    end

    // Request payload latched on acceptance; writes carry tag 0.
    always_comb begin
        out_d = out_q;
        if (accept) begin
            out_d.write = win_write;
            out_d.addr  = win_addr;
            out_d.src   = win_idx;
            out_d.tag   = win_write ? '0 : {win_idx, win_seq};
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cpl_error_q <= 1'b0;
            out_q       <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
                seq_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cpl_error_q <= cpl_error_d;
            out_q       <= out_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
                seq_q[i] <= seq_d[i];
            end
        end
    end

    // Flatten the counters onto the status port.
    always_comb begin
        outstanding = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            outstanding[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign out_write = out_q.write;
    assign out_addr  = out_q.addr;
    assign out_tag   = out_q.tag;
    assign out_src   = out_q.src;
    assign cpl_error = cpl_error_q;

endmodule

// File: tb/tb_hififo_request_arbiter.sv
// Directed bench for hififo_request_arbiter (NREQ=4, MAX_OUTSTANDING=8).
module tb_hififo_request_arbiter;

    localparam int unsigned NREQ = 4;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [64*NREQ-1:0]  req_addr;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic                out_ready;
    logic                out_write;
    logic [63:0]         out_addr;
    logic [7:0]          out_tag;
    logic [2:0]          out_src;
    logic                cpl_valid;
    logic [7:0]          cpl_tag;
    logic                cpl_last;
    logic [4*NREQ-1:0]   outstanding;
    logic                cpl_error;

    int n_checks = 0;
    int n_pass   = 0;

    hififo_request_arbiter #(.NREQ(4), .MAX_OUTSTANDING(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_write   (out_write),
        .out_addr    (out_addr),
        .out_tag     (out_tag),
        .out_src     (out_src),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .cpl_last    (cpl_last),
        .outstanding (outstanding),
        .cpl_error   (cpl_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] addr_of(input int r);
        addr_of = 64'hFEED_0000_0000_00AB | (64'(r) << 12);
    endfunction

    function automatic logic [3:0] onehot(input int r);
        logic [3:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] cnt_of(input int r);
        return outstanding[4*r +: 4];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete request from requester r with out_ready high.
    task automatic issue(input int r, input logic wr, input logic [7:0] exp_tag);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        out_ready    = 1'b1;
        #1;
        check_eq("issue_ready", 64'(req_ready), 64'(onehot(r)));
        tick();
        req_valid[r] = 1'b0;
        check_eq("issue_valid", 64'(out_valid), 64'd1);
        check_eq("issue_src", 64'(out_src), 64'(r));
        check_eq("issue_tag", 64'(out_tag), 64'(exp_tag));
        check_eq("issue_addr", out_addr, addr_of(r));
        tick();
    endtask

    // One final completion beat.
    task automatic cpl(input logic [7:0] t);
        cpl_valid = 1'b1;
        cpl_tag   = t;
        cpl_last  = 1'b1;
        tick();
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
        cpl_tag   = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        out_ready = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag   = '0;
        cpl_last  = 1'b0;
        for (int r = 0; r < 4; r++) req_addr[64*r +: 64] = addr_of(r);

        // Reset state, with requests already pending.
        repeat (2) tick();
        req_valid = 4'hF;
        req_write = 4'hF;
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_addr", out_addr, 64'd0);
        check_eq("rst_tag", 64'(out_tag), 64'd0);
        check_eq("rst_cnt", 64'(outstanding), 64'd0);
        check_eq("rst_err", 64'(cpl_error), 64'd0);

        // Round robin over four writers, one request every two cycles.
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            int s;
            s = g % 4;
            check_eq("rr_ready", 64'(req_ready), 64'(onehot(s)));
            check_eq("rr_idle_valid", 64'(out_valid), 64'd0);
            tick();
            check_eq("rr_valid", 64'(out_valid), 64'd1);
            check_eq("rr_src", 64'(out_src), 64'(s));
            check_eq("rr_addr", out_addr, addr_of(s));
            check_eq("rr_write", 64'(out_write), 64'd1);
            check_eq("rr_tag", 64'(out_tag), 64'd0);
            check_eq("rr_send_ready", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = '0;

        // Backpressure: requester 1 (rr_ptr=1) held in SEND for 10 cycles.
        out_ready = 1'b0;
        req_valid = 4'b0010;
        req_write = 4'b1111;
        #1;
        check_eq("bp_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_src", 64'(out_src), 64'd1);
            check_eq("bp_addr", out_addr, addr_of(1));
            check_eq("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_hs_valid", 64'(out_valid), 64'd1);
        check_eq("bp_hs_ready", 64'(req_ready), 64'd0);
        tick();
        check_eq("bp_idle_valid", 64'(out_valid), 64'd0);
        check_eq("bp_idle_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        check_eq("bp_next_src", 64'(out_src), 64'd0);
        tick();
        req_write = '0;

        // Tags on requester 2: first eight reads fill the window.
        for (int n = 0; n < 8; n++) begin
            issue(2, 1'b0, 8'h40 | 8'(n));
            check_eq("tag_cnt", 64'(cnt_of(2)), 64'(n + 1));
        end
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        #1;
        check_eq("tag_full_ready", 64'(req_ready), 64'd0);
        tick();
        check_eq("tag_full_valid", 64'(out_valid), 64'd0);
        cpl_valid = 1'b1;
        cpl_tag   = 8'h40;
        cpl_last  = 1'b1;
        #1;
        check_eq("tag_cpl_same_cycle", 64'(req_ready), 64'd0);
        tick();
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
        check_eq("tag_cnt_after_cpl", 64'(cnt_of(2)), 64'd7);
        issue(2, 1'b0, 8'h48);
        for (int n = 9; n < 33; n++) begin
            cpl(8'h40 | 8'((n - 8) % 32));
            issue(2, 1'b0, 8'h40 | 8'(n % 32));
        end
        check_eq("tag_cnt_sat", 64'(cnt_of(2)), 64'd8);
        for (int m = 25; m < 33; m++) cpl(8'h40 | 8'(m % 32));
        check_eq("tag_cnt_drained", 64'(cnt_of(2)), 64'd0);

        // Requester 0 full of reads is skipped in favour of a write on 1.
        for (int k = 0; k < 8; k++) issue(0, 1'b0, 8'(k));
        issue(3, 1'b1, 8'h00);
        check_eq("byp_cnt0", 64'(cnt_of(0)), 64'd8);
        req_valid = 4'b0011;
        req_write = 4'b0010;
        #1;
        check_eq("byp_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        check_eq("byp_src", 64'(out_src), 64'd1);
        check_eq("byp_write", 64'(out_write), 64'd1);
        tick();
        check_eq("byp_blocked", 64'(req_ready), 64'd0);
        cpl_valid = 1'b1;
        cpl_tag   = 8'h00;
        cpl_last  = 1'b1;
        #1;
        check_eq("byp_blocked_cpl", 64'(req_ready), 64'd0);
        tick();
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
        check_eq("byp_cnt0_dec", 64'(cnt_of(0)), 64'd7);
        check_eq("byp_freed", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        check_eq("byp_src0", 64'(out_src), 64'd0);
        check_eq("byp_tag0", 64'(out_tag), 64'h08);
        check_eq("byp_read0", 64'(out_write), 64'd0);
        tick();
        req_write = '0;

        // Same-cycle read accept and last completion on requester 3.
        issue(3, 1'b0, 8'h60);
        check_eq("sim_cnt3_pre", 64'(cnt_of(3)), 64'd1);
        req_valid = 4'b1000;
        cpl_valid = 1'b1;
        cpl_tag   = 8'h60;
        cpl_last  = 1'b1;
        #1;
        check_eq("sim_ready", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
        check_eq("sim_cnt3", 64'(cnt_of(3)), 64'd1);
        check_eq("sim_tag", 64'(out_tag), 64'h61);
        check_eq("sim_err", 64'(cpl_error), 64'd0);
        tick();

        // Completion for idle requester 1 raises sticky error.
        cpl(8'h20);
        check_eq("err_set", 64'(cpl_error), 64'd1);
        check_eq("err_cnt1", 64'(cnt_of(1)), 64'd0);
        repeat (3) tick();
        check_eq("err_sticky", 64'(cpl_error), 64'd1);

        // Reset in SEND drops the request without a clock edge.
        out_ready = 1'b0;
        req_valid = 4'b0100;
        req_write = 4'b0100;
        #1;
        check_eq("rs_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check_eq("rs_send", 64'(out_valid), 64'd1);
        check_eq("rs_send_src", 64'(out_src), 64'd2);
        reset = 1'b1;
        #1;
        check_eq("rs_async_valid", 64'(out_valid), 64'd0);
        check_eq("rs_err", 64'(cpl_error), 64'd0);
        check_eq("rs_cnt", 64'(outstanding), 64'd0);
        check_eq("rs_src", 64'(out_src), 64'd0);
        repeat (2) tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'hF;
        req_write = 4'hF;
        #1;
        check_eq("rs_first_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        check_eq("rs_first_src", 64'(out_src), 64'd0);
        check_eq("rs_first_valid", 64'(out_valid), 64'd1);
        check_eq("rs_first_addr", out_addr, addr_of(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
